// File: rtl/commit_trace_tx_pkg.sv
// Shared definitions for the commit trace transmitter.
// Contents:
//   REC_*   - record-type encodings driven on rec_type
//   STAT_*  - statistics counter indices, also the order of STAT records
//   state_e - transmitter phase
//   rec_t   - one trace record as stored in the FIFO
package commit_trace_tx_pkg;

    localparam logic [2:0] REC_REG   = 3'd0;
    localparam logic [2:0] REC_LOAD  = 3'd1;
    localparam logic [2:0] REC_STORE = 3'd2;
    localparam logic [2:0] REC_HALT  = 3'd3;
    localparam logic [2:0] REC_STAT  = 3'd4;

    localparam int N_STAT = 6;
    localparam logic [2:0] STAT_CYCLE = 3'd0;
    localparam logic [2:0] STAT_INST  = 3'd1;
    localparam logic [2:0] STAT_DHIT  = 3'd2;
    localparam logic [2:0] STAT_IHIT  = 3'd3;
    localparam logic [2:0] STAT_DREQ  = 3'd4;
    localparam logic [2:0] STAT_IREQ  = 3'd5;

    // Two halves per counter, so the last STAT record is {index 5, half 1}.
    localparam logic [3:0] STAT_LAST = 4'd11;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_SUMMARY = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  rtype;
        logic [15:0] addr;
        logic [15:0] data;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Two-write / one-read synchronous record FIFO.
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   push0_i, wdata0_i    - first write of the cycle
//   push1_i, wdata1_i    - second write, only meaningful together with push0_i
//   pop_i                - remove the head entry (caller guarantees non-empty)
//   rdata_o              - head entry, read straight from the storage flops
//   count_o              - occupancy, one bit wider than the pointers
// The caller checks free space (including a same-cycle pop) before pushing,
// so a push never lands on an occupied slot.
module trace_fifo
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push0_i,
    input  logic                     push1_i,
    input  logic [REC_W-1:0]         wdata0_i,
    input  logic [REC_W-1:0]         wdata1_i,
    input  logic                     pop_i,
    output logic [REC_W-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [1:0]       n_push;

    assign n_push = {1'b0, push0_i} + {1'b0, push1_i};

    // Storage is not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[wr_ptr_q] <= wdata0_i;
        if (push1_i) mem_q[wr_ptr_q + AW'(1)] <= wdata1_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop_i);
            count_q  <= count_q + CW'(n_push) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: turns per-cycle commit events into REG/LOAD/STORE
// records, a HALT record, then a summary of six statistics counters.
// Ports:
//   clk, rst (sync, active-low)
//   RegWrite/WriteRegister/WriteData, MemRead/MemWrite/MemAddress/MemData,
//   Halt, I/DCache Req/Hit            - commit and cache events
//   rec_valid/rec_ready, rec_type/rec_addr/rec_data - record stream
//   trace_stall, overflow, done       - status
//   dbg_state_o                       - current phase (state_e encoding)
// Record stream: a record transfers on a cycle where rec_valid && rec_ready;
// while rec_valid is high and rec_ready low the record is held unchanged and
// rec_valid stays high until it transfers.
module commit_trace_tx
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [2:0]  WriteRegister,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemData,
    input  logic        Halt,
    input  logic        ICacheReq,
    input  logic        ICacheHit,
    input  logic        DCacheReq,
    input  logic        DCacheHit,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_type,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_data,
    output logic        trace_stall,
    output logic        overflow,
    output logic        done,
    output logic [1:0]  dbg_state_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_STAT];
    logic [CNT_W-1:0] cnt_d [N_STAT];
    logic             halt_pend_q, halt_pend_d;
    logic [15:0]      halt_data_q, halt_data_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       sidx_q, sidx_d;

    logic             push0, push1, pop, has_mem, fifo_empty;
    rec_t             wdata0, wdata1, reg_rec, mem_rec, halt_rec, fifo_head;
    logic [REC_W-1:0] fifo_rdata;
    logic [CW-1:0]    fifo_count, space;
    logic [1:0]       n_rec;
    logic [CNT_W-1:0] stat_sel;
    logic [31:0]      stat32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) return v + CNT_ONE;
        return v;
    endfunction

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i    (clk),
        .rst_ni   (rst),
        .push0_i  (push0),
        .push1_i  (push1),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .pop_i    (pop),
        .rdata_o  (fifo_rdata),
        .count_o  (fifo_count)
    );

    assign fifo_head  = fifo_rdata;
    assign fifo_empty = (fifo_count == '0);
    assign has_mem    = MemRead | MemWrite;
    assign reg_rec    = '{rtype: REC_REG, addr: {13'd0, WriteRegister}, data: WriteData};
    // A cycle with both MemRead and MemWrite is reported as a store only.
    assign mem_rec    = '{rtype: (MemWrite ? REC_STORE : REC_LOAD), addr: MemAddress, data: MemData};
    assign halt_rec   = '{rtype: REC_HALT, addr: 16'd0, data: halt_data_q};

    assign pop   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty && rec_ready;
    // Free entries this cycle, counting the slot a simultaneous pop releases.
    assign space = CW'(DEPTH) - fifo_count + CW'(pop);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_pend_d = halt_pend_q;
        halt_data_d = halt_data_q;
        ovf_d       = ovf_q;
        sidx_d      = sidx_q;
        push0       = 1'b0;
        push1       = 1'b0;
        wdata0      = reg_rec;
        wdata1      = mem_rec;
        n_rec       = 2'd0;
        case (state_q)
            ST_RUN: begin
                if (RegWrite) begin
                    n_rec = 2'd1 + {1'b0, has_mem};
                end else begin
                    wdata0 = mem_rec;
                    n_rec  = {1'b0, has_mem};
                end
                // All records of a cycle go in together or are all dropped.
                if (n_rec != 2'd0) begin
                    if (CW'(n_rec) <= space) begin
                        push0 = 1'b1;
                        push1 = (n_rec == 2'd2);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                cnt_d[STAT_CYCLE] = sat_inc(cnt_q[STAT_CYCLE], 1'b1);
                cnt_d[STAT_INST]  = sat_inc(cnt_q[STAT_INST], Halt | RegWrite | MemWrite);
                cnt_d[STAT_DHIT]  = sat_inc(cnt_q[STAT_DHIT], DCacheHit);
                cnt_d[STAT_IHIT]  = sat_inc(cnt_q[STAT_IHIT], ICacheHit);
                cnt_d[STAT_DREQ]  = sat_inc(cnt_q[STAT_DREQ], DCacheReq);
                cnt_d[STAT_IREQ]  = sat_inc(cnt_q[STAT_IREQ], ICacheReq);
                // HALT is queued in the following cycle so it always follows
                // this cycle's own records.
                if (Halt) begin
                    state_d     = ST_DRAIN;
                    halt_pend_d = 1'b1;
                    halt_data_d = cnt_d[STAT_INST][15:0];
                end
            end
            ST_DRAIN: begin
                if (halt_pend_q) begin
                    wdata0 = halt_rec;
                    // The HALT record waits for space rather than being lost.
                    if (space != '0) begin
                        push0       = 1'b1;
                        halt_pend_d = 1'b0;
                    end
                end else if (fifo_empty) begin
                    state_d = ST_SUMMARY;
                end
            end
            ST_SUMMARY: begin
                if (rec_ready) begin
                    if (sidx_q == STAT_LAST) state_d = ST_DONE;
                    else                     sidx_d  = sidx_q + 4'd1;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            for (int i = 0; i < N_STAT; i++) cnt_q[i] <= '0;
            halt_pend_q <= 1'b0;
            halt_data_q <= '0;
            ovf_q       <= 1'b0;
            sidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halt_pend_q <= halt_pend_d;
            halt_data_q <= halt_data_d;
            ovf_q       <= ovf_d;
            sidx_q      <= sidx_d;
        end
    end

    // sidx_q is {counter index, half}; the summary value is sent as 32 bits.
    assign stat_sel = cnt_q[sidx_q[3:1]];
    generate
        if (CNT_W >= 32) begin : g_stat_trunc
            assign stat32 = stat_sel[31:0];
        end else begin : g_stat_ext
            assign stat32 = {{(32-CNT_W){1'b0}}, stat_sel};
        end
    endgenerate

    always_comb begin
        rec_valid = 1'b0;
        rec_type  = fifo_head.rtype;
        rec_addr  = fifo_head.addr;
        rec_data  = fifo_head.data;
        case (state_q)
            ST_SUMMARY: begin
                rec_valid = 1'b1;
                rec_type  = REC_STAT;
                rec_addr  = {12'd0, sidx_q};
                rec_data  = sidx_q[0] ? stat32[31:16] : stat32[15:0];
            end
            ST_DONE: begin
                rec_type = 3'd0;
                rec_addr = 16'd0;
                rec_data = 16'd0;
            end
            default: rec_valid = !fifo_empty;
        endcase
    end

    assign trace_stall = (CW'(DEPTH) - fifo_count) < CW'(2);
    assign overflow    = ovf_q;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule
